wb_burst_master: RTL



---
 rtl/wb_burst_master.sv | 193 +++++++++++++++++++
 1 files changed

// File: rtl/wb_burst_master.sv
// wb_burst_master: Wishbone pipelined-mode burst master.
// Turns one command (start address, beat count, direction, byte select) into
// an incrementing-address burst of 1-16 32-bit beats and holds CYC until
// every issued beat has been acknowledged or the slave signals an error.
//
// Ports
//   CLK, RST_SYNC          clock, synchronous active-high reset
//   EN                     command-accept enable (in-flight bursts always finish)
//   CMD_*                  command channel (valid/ready handshake)
//   WR_DAT_*               write data stream feeding WB_WR_DAT_OUT
//   RD_DAT_VALID_OUT/OUT   read data, one pulse per acknowledged read beat
//   DONE_OUT, ERR_OUT      end-of-burst pulses (clean / aborted)
//   WB_*                   Wishbone master-side bus signals

module wb_burst_master #(
    parameter bit BURST_CTI_EN = 1'b1
) (
    input  logic        CLK,
    input  logic        RST_SYNC,
    input  logic        EN,
    input  logic        CMD_VALID_IN,
    output logic        CMD_READY_OUT,
    input  logic [31:0] CMD_ADR_IN,
    input  logic [3:0]  CMD_LEN_IN,
    input  logic        CMD_WE_IN,
    input  logic [3:0]  CMD_SEL_IN,
    input  logic        WR_DAT_VALID_IN,
    output logic        WR_DAT_READY_OUT,
    input  logic [31:0] WR_DAT_IN,
    output logic        RD_DAT_VALID_OUT,
    output logic [31:0] RD_DAT_OUT,
    output logic        DONE_OUT,
    output logic        ERR_OUT,
    output logic [31:0] WB_ADR_OUT,
    output logic        WB_CYC_OUT,
    output logic        WB_STB_OUT,
    output logic        WB_WE_OUT,
    output logic [3:0]  WB_SEL_OUT,
    output logic [2:0]  WB_CTI_OUT,
    output logic [1:0]  WB_BTE_OUT,
    input  logic        WB_STALL_IN,
    input  logic        WB_ACK_IN,
    input  logic        WB_ERR_IN,
    input  logic [31:0] WB_RD_DAT_IN,
    output logic [31:0] WB_WR_DAT_OUT
);

    localparam int unsigned ADR_W = 32;
    localparam int unsigned DAT_W = 32;
    localparam int unsigned LEN_W = 4;
    localparam int unsigned SEL_W = 4;
    localparam int unsigned CNT_W = 5;

    localparam logic [2:0] CTI_CLASSIC = 3'b000;
    localparam logic [2:0] CTI_INCR    = 3'b010;
    localparam logic [2:0] CTI_END     = 3'b111;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2
    } state_e;

    state_e             state_q;
    logic               cyc_q;
    logic [ADR_W-1:0]   adr_q;
    logic               we_q;
    logic [SEL_W-1:0]   sel_q;
    logic [2:0]         cti_q;
    logic [LEN_W-1:0]   len_q;
    logic [CNT_W-1:0]   issue_cnt_q;
    logic [CNT_W-1:0]   ack_cnt_q;
    logic [DAT_W-1:0]   rd_dat_q;
    logic               rd_vld_q;
    logic               done_q;
    logic               err_q;

    logic               cmd_fire;
    logic               stb;
    logic               accept;
    logic               last_beat;
    logic               ack_hit;
    logic               err_hit;
    logic               burst_end;
    logic               unused_adr_lsb;

    // Address bits [1:0] are forced to zero; beats are always word aligned.
    assign unused_adr_lsb = ^CMD_ADR_IN[1:0];

    // CTI tag for beat index idx of a burst whose last beat index is len.
    function automatic logic [2:0] cti_for(input logic [CNT_W-1:0] idx,
                                           input logic [LEN_W-1:0] len);
        if (!BURST_CTI_EN || len == '0) begin
            return CTI_CLASSIC;
        end else if (idx == CNT_W'(len)) begin
            return CTI_END;
        end else begin
            return CTI_INCR;
        end
    endfunction

    // Handshake and bus-response qualifiers; ERR masks both STB and ACK.
    assign cmd_fire  = CMD_VALID_IN && CMD_READY_OUT;
    assign stb       = (state_q == S_ISSUE) && (!we_q || WR_DAT_VALID_IN) && !WB_ERR_IN;
    assign accept    = stb && !WB_STALL_IN;
    assign last_beat = issue_cnt_q == CNT_W'(len_q);
    assign ack_hit   = cyc_q && WB_ACK_IN && !WB_ERR_IN;
    assign err_hit   = cyc_q && WB_ERR_IN;
    assign burst_end = ack_hit && (ack_cnt_q == CNT_W'(len_q));

    // Burst sequencer with registered bus and status outputs.
    always_ff @(posedge CLK) begin
        if (RST_SYNC) begin
            state_q     <= S_IDLE;
            cyc_q       <= 1'b0;
            adr_q       <= '0;
            we_q        <= 1'b0;
            sel_q       <= '0;
            cti_q       <= '0;
            len_q       <= '0;
            issue_cnt_q <= '0;
            ack_cnt_q   <= '0;
            rd_dat_q    <= '0;
            rd_vld_q    <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            rd_vld_q <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (cmd_fire) begin
                        adr_q       <= {CMD_ADR_IN[ADR_W-1:2], 2'b00};
                        len_q       <= CMD_LEN_IN;
                        we_q        <= CMD_WE_IN;
                        sel_q       <= CMD_SEL_IN;
                        cti_q       <= cti_for('0, CMD_LEN_IN);
                        issue_cnt_q <= '0;
                        ack_cnt_q   <= '0;
                        cyc_q       <= 1'b1;
                        state_q     <= S_ISSUE;
                    end
                end
                default: begin
                    if (err_hit) begin
                        cyc_q   <= 1'b0;
                        err_q   <= 1'b1;
                        state_q <= S_IDLE;
                    end else begin
                        if (ack_hit) begin
                            ack_cnt_q <= ack_cnt_q + CNT_W'(1);
                            if (!we_q) begin
                                rd_dat_q <= WB_RD_DAT_IN;
                                rd_vld_q <= 1'b1;
                            end
                        end
                        if (accept) begin
                            issue_cnt_q <= issue_cnt_q + CNT_W'(1);
                            adr_q       <= adr_q + ADR_W'(4);
                            cti_q       <= cti_for(issue_cnt_q + CNT_W'(1), len_q);
                            if (last_beat) begin
                                state_q <= S_WAIT;
                            end
                        end
                        // Final ack may coincide with the last accept; it takes priority.
                        if (burst_end) begin
                            cyc_q   <= 1'b0;
                            done_q  <= 1'b1;
                            state_q <= S_IDLE;
                        end
                    end
                end
            endcase
        end
    end

    assign CMD_READY_OUT    = EN && (state_q == S_IDLE);
    assign WB_STB_OUT       = stb;
    assign WR_DAT_READY_OUT = we_q && accept;
    assign WB_WR_DAT_OUT    = WR_DAT_IN;
    assign WB_ADR_OUT       = adr_q;
    assign WB_CYC_OUT       = cyc_q;
    assign WB_WE_OUT        = we_q;
    assign WB_SEL_OUT       = sel_q;
    assign WB_CTI_OUT       = cti_q;
    assign WB_BTE_OUT       = 2'b00;
    assign RD_DAT_OUT       = rd_dat_q;
    assign RD_DAT_VALID_OUT = rd_vld_q;
    assign DONE_OUT         = done_q;
    assign ERR_OUT          = err_q;

endmodule
